if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 87 ++++++++
 tb/tb_if_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: drives one outstanding instruction-memory request at a
// time, holds the fetched word for IF/ID and squashes in-flight words on redirect.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        b_flag,
    input  logic [31:0] b_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] tgt;
    logic [31:0] pc_inc;
    logic        unused_bits;

    assign tgt         = {b_target[31:2], 2'b00};
    assign pc_inc      = pc + 32'd4;
    assign unused_bits = ^{stall[5:1], b_target[1:0]};

    assign mem_req     = (state != S_HOLD);
    assign stallreq_if = (state != S_HOLD);
    assign mem_addr    = req_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            if_pc    <= 32'h0;
            if_inst  <= 32'h0;
        end else if (b_flag) begin
            pc      <= tgt;
            if_pc   <= 32'h0;
            if_inst <= 32'h0;
            // A request still in flight must complete before the target can be issued.
            if ((state == S_REQ || state == S_DISCARD) && !mem_ready) begin
                state <= S_DISCARD;
            end else begin
                req_addr <= tgt;
                state    <= S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (mem_ready) begin
                        if_pc   <= pc;
                        if_inst <= mem_rdata;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall[0]) begin
                        pc       <= pc_inc;
                        req_addr <= pc_inc;
                        state    <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    // Stale word is dropped; reissue at the redirected pc.
                    if (mem_ready) begin
                        req_addr <= pc;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against a transaction-level model of the fetch
// stage (one outstanding request, stale flag, held word).
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        b_flag;
    logic [31:0] b_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [31:0] m_pc, m_addr, m_if_pc, m_if_inst;
    bit          m_pending, m_stale;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .b_flag     (b_flag),
        .b_target   (b_target),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .stallreq_if(stallreq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_addr    = 32'h0;
        m_pending = 1'b1;
        m_stale   = 1'b0;
        m_if_pc   = 32'h0;
        m_if_inst = 32'h0;
    endtask

    // One clock edge of the fetch contract, in terms of requests rather than states.
    task automatic model_edge();
        if (b_flag) begin
            m_pc      = {b_target[31:2], 2'b00};
            m_if_pc   = 32'h0;
            m_if_inst = 32'h0;
            if (m_pending && !mem_ready) m_stale = 1'b1;
            else begin
                m_pending = 1'b1;
                m_stale   = 1'b0;
                m_addr    = m_pc;
            end
        end else if (m_pending) begin
            if (mem_ready) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_addr  = m_pc;
                end else begin
                    m_if_pc   = m_addr;
                    m_if_inst = mem_rdata;
                    m_pending = 1'b0;
                end
            end
        end else if (!stall[0]) begin
            m_pc      = m_pc + 32'd4;
            m_addr    = m_pc;
            m_pending = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mem_req"},  {31'h0, mem_req},     {31'h0, m_pending});
        chk({tag, ".stallreq"}, {31'h0, stallreq_if}, {31'h0, m_pending});
        chk({tag, ".mem_addr"}, mem_addr, m_addr);
        chk({tag, ".if_pc"},    if_pc,    m_if_pc);
        chk({tag, ".if_inst"},  if_inst,  m_if_inst);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit rdy, input logic [31:0] rd, input bit st, input bit br,
                         input logic [31:0] bt);
        mem_ready = rdy;
        mem_rdata = rd;
        stall     = {5'b10101, st};
        b_flag    = br;
        b_target  = bt;
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0);
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // first fetch: ready two cycles after release
        step("rel0");
        step("rel1");
        drive(1, 32'h0000_0013, 0, 0, 32'h0);
        step("first");
        chk("first.if_inst", if_inst, 32'h0000_0013);
        chk("first.if_pc",   if_pc,   32'h0);
        drive(0, 32'h0, 0, 0, 32'h0);

        // back-to-back fetch 4, 8, 12
        for (int i = 0; i < 6; i++) begin
            drive(mem_req, 32'h1000 + i, 0, 0, 32'h0);
            step("b2b");
        end
        chk("b2b.if_pc", if_pc, 32'd12);

        // hold under stall for 3 cycles, then release
        drive(0, 32'h0, 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall.if_pc", if_pc, 32'd12);
        drive(0, 32'h0, 0, 0, 32'h0);
        step("unstall");
        chk("unstall.addr", mem_addr, 32'd16);

        // redirect while request pending -> discard the returning word
        drive(0, 32'h0, 0, 1, 32'h0000_0103);
        step("disc_br");
        drive(0, 32'h0, 0, 0, 32'h0);
        step("disc_wait");
        chk("disc.addr_stable", mem_addr, 32'd16);
        drive(1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        step("disc_drop");
        chk("disc.if_inst", if_inst, 32'h0);
        chk("disc.next_addr", mem_addr, 32'h100);
        drive(1, 32'h0000_0093, 0, 0, 32'h0);
        step("disc_fetch");
        chk("disc.if_pc", if_pc, 32'h100);

        // redirect coincident with ready in REQ
        drive(0, 32'h0, 0, 0, 32'h0);
        step("co_adv");
        drive(1, 32'hBAD0_0001, 0, 1, 32'h0000_0200);
        step("co_br");
        chk("co.addr", mem_addr, 32'h200);
        chk("co.if_inst", if_inst, 32'h0);

        // pc wrap from FFFF_FFFC
        drive(1, 32'h1111_1111, 0, 1, 32'hFFFF_FFFE);
        step("wr_br");
        drive(1, 32'h2222_2222, 0, 0, 32'h0);
        step("wr_fetch");
        chk("wr.if_pc", if_pc, 32'hFFFF_FFFC);
        drive(0, 32'h0, 0, 0, 32'h0);
        step("wr_adv");
        chk("wr.addr", mem_addr, 32'h0);

        // reset mid-REQ
        async_reset("rst_mid");

        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            mem_ready = ($urandom_range(1) == 1);
            mem_rdata = $urandom;
            stall     = 6'($urandom);
            stall[0]  = ($urandom_range(2) == 0);
            b_flag    = ($urandom_range(7) == 0);
            b_target  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15))
                                                 : $urandom;
            if ($urandom_range(499) == 0) async_reset("rnd_rst");
            else step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
